// File: rtl/gen_tp_pkg.sv
// ============================================================================
//  gen_tp_pkg : shared types, constants and nibble helpers for gen_teamplayer
//  Rev 1.0
// ============================================================================
`default_nettype none

package gen_tp_pkg;

    typedef enum logic [1:0] {
        PT_3B   = 2'b00,
        PT_6B   = 2'b01,
        PT_NONE = 2'b11
    } pad_type_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } tp_state_e;

    localparam logic [3:0]  c_ID_NIB     = 4'h3;
    // Header nibbles for indices 0..3, index 0 in the low nibble
    localparam logic [15:0] c_HDR_NIBS   = {4'h0, 4'h0, 4'hF, 4'h3};
    localparam logic [3:0]  c_TNIB_3B    = 4'h0;
    localparam logic [3:0]  c_TNIB_6B    = 4'h1;
    localparam logic [3:0]  c_TNIB_NONE  = 4'hF;
    localparam logic [3:0]  c_NIB_FILL   = 4'hF;
    localparam logic [5:0]  c_DATA_BASE  = 6'd8;
    localparam int          c_MAX_NIB    = 20;

    function automatic logic [1:0] nib_cnt(input logic [1:0] i_t);
        case (i_t)
            PT_3B:   nib_cnt = 2'd2;
            PT_6B:   nib_cnt = 2'd3;
            default: nib_cnt = 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] type_nib(input logic [1:0] i_t);
        case (i_t)
            PT_3B:   type_nib = c_TNIB_3B;
            PT_6B:   type_nib = c_TNIB_6B;
            default: type_nib = c_TNIB_NONE;
        endcase
    endfunction

    // Buttons are {Z,Y,X,MODE,START,C,B,A,RIGHT,LEFT,DOWN,UP}, bit 11 down to 0
    function automatic logic [3:0] pad_nib(input logic [11:0] i_b, input logic [1:0] i_sel);
        case (i_sel)
            2'd0:    pad_nib = i_b[3:0];
            2'd1:    pad_nib = {i_b[7], i_b[4], i_b[6], i_b[5]};
            default: pad_nib = {i_b[8], i_b[9], i_b[10], i_b[11]};
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/gen_teamplayer_nib_sched.sv
// ============================================================================
//  tp_nib_sched : combinational index-to-nibble mapping over the frame snapshot
//  Rev 1.0
// ============================================================================
`default_nettype none

module tp_nib_sched
    import gen_tp_pkg::*;
(
    input  logic [4:0]  i_idx,
    input  logic [7:0]  i_type,
    input  logic [47:0] i_btn,
    output logic [3:0]  o_nib
);

    logic [1:0] w_cnt  [4];
    logic [5:0] w_off  [4];
    logic [5:0] w_rel  [4];
    logic       w_hit  [4];
    logic [3:0] w_pnib [4];

    // Pad start offsets as a non-chained prefix sum of per-pad nibble counts
    assign w_off[0] = c_DATA_BASE;
    assign w_off[1] = c_DATA_BASE + {4'b0, w_cnt[0]};
    assign w_off[2] = c_DATA_BASE + {4'b0, w_cnt[0]} + {4'b0, w_cnt[1]};
    assign w_off[3] = c_DATA_BASE + {4'b0, w_cnt[0]} + {4'b0, w_cnt[1]} + {4'b0, w_cnt[2]};

    generate
        for (genvar p = 0; p < 4; p++) begin : g_pad
            assign w_cnt[p]  = nib_cnt(i_type[2*p +: 2]);
            assign w_rel[p]  = {1'b0, i_idx} - w_off[p];
            assign w_hit[p]  = ({1'b0, i_idx} >= w_off[p]) && (w_rel[p] < {4'b0, w_cnt[p]});
            assign w_pnib[p] = pad_nib(i_btn[12*p +: 12], w_rel[p][1:0]);
        end
    endgenerate

    always_comb begin
        o_nib = c_NIB_FILL;
        if (i_idx < 5'd4) begin
            o_nib = c_HDR_NIBS[{i_idx[1:0], 2'b00} +: 4];
        end else if (i_idx < 5'd8) begin
            o_nib = type_nib(i_type[{i_idx[1:0], 1'b0} +: 2]);
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (w_hit[p]) o_nib = w_pnib[p];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/gen_teamplayer.sv
// ============================================================================
//  gen_teamplayer : four-pad multitap, TH/TR/TL nibble handshake sequencer
//  Rev 1.0
// ============================================================================
`default_nettype none

module gen_teamplayer
    import gen_tp_pkg::*;
#(
    parameter int ACK_DLY = 8,
    parameter int TMO     = 4095
) (
    input  logic        RESET,
    input  logic        CLK,
    input  logic        CE,
    input  logic [7:0]  TYPE,
    input  logic [11:0] P1_BTN,
    input  logic [11:0] P2_BTN,
    input  logic [11:0] P3_BTN,
    input  logic [11:0] P4_BTN,
    input  logic        TH,
    input  logic        TR,
    output logic [3:0]  DO,
    output logic        TL,
    output logic        BUSY
);

    localparam int c_ACK_W = $clog2(ACK_DLY + 1);
    localparam int c_TMO_W = $clog2(TMO + 1);
    localparam logic [c_ACK_W-1:0] c_ACK_LOAD = c_ACK_W'(ACK_DLY);
    localparam logic [c_ACK_W-1:0] c_ACK_ONE  = c_ACK_W'(1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TMO - 1);

    tp_state_e          r_state;
    logic               r_th;
    logic               r_tr;
    logic               r_tl;
    logic [4:0]         r_idx;
    logic [c_ACK_W-1:0] r_ack;
    logic [c_TMO_W-1:0] r_tmo;
    logic [7:0]         r_type;
    logic [47:0]        r_btn;
    logic [3:0]         w_nib;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_th    <= 1'b1;
            r_tr    <= 1'b0;
            r_tl    <= 1'b1;
            r_idx   <= '0;
            r_ack   <= '0;
            r_tmo   <= '0;
            r_type  <= '0;
            r_btn   <= '0;
        end else if (CE) begin
            r_th <= TH;
            r_tr <= TR;
            if (TH) begin
                // Abort path: TH high wins over any pending acknowledge
                r_state <= ST_IDLE;
                r_tl    <= 1'b1;
                r_idx   <= '0;
                r_ack   <= '0;
                r_tmo   <= '0;
            end else if (r_th) begin
                r_state <= ST_SEQ;
                r_tl    <= 1'b1;
                r_idx   <= '0;
                r_ack   <= '0;
                r_tmo   <= '0;
                r_type  <= TYPE;
                r_btn   <= {P4_BTN, P3_BTN, P2_BTN, P1_BTN};
            end else if (r_state == ST_SEQ) begin
                if (TR != r_tr) begin
                    r_ack <= c_ACK_LOAD;
                    r_tmo <= '0;
                end else begin
                    if (r_ack != '0) begin
                        r_ack <= r_ack - c_ACK_ONE;
                        // A double toggle inside the window leaves TR == TL: no advance
                        if (r_ack == c_ACK_ONE && TR != r_tl) begin
                            r_tl <= TR;
                            if (r_idx != 5'd31) r_idx <= r_idx + 5'd1;
                        end
                    end
                    if (r_tmo == c_TMO_LAST) begin
                        r_idx <= '0;
                        r_tmo <= '0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
            end
        end
    end

    tp_nib_sched u_sched (
        .i_idx  (r_idx),
        .i_type (r_type),
        .i_btn  (r_btn),
        .o_nib  (w_nib)
    );

    assign DO   = (r_state == ST_SEQ) ? w_nib : c_ID_NIB;
    assign TL   = r_tl;
    assign BUSY = (r_state == ST_SEQ);

endmodule

`default_nettype wire

// File: tb/tb_gen_teamplayer.sv
// ============================================================================
//  tb_gen_teamplayer : self-checking bench for the gen_teamplayer multitap
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_gen_teamplayer;

    localparam int ACK_DLY = 8;
    localparam int TMO     = 4095;

    localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3;
    localparam int B_A = 4, B_B = 5, B_C = 6, B_START = 7;
    localparam int B_MODE = 8, B_X = 9, B_Y = 10, B_Z = 11;

    logic        clk = 1'b0;
    logic        rst, ce, th, tr;
    logic [7:0]  ty;
    logic [11:0] p1, p2, p3, p4;
    logic [3:0]  w_do;
    logic        w_tl, w_busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  s_ty;
    logic [47:0] s_bb;
    int          m_idx;
    logic        m_tl;

    typedef struct {
        logic       tr;
        logic [3:0] exp_do;
        logic       exp_tl;
    } vec_t;

    vec_t tbl[14];

    gen_teamplayer #(.ACK_DLY(ACK_DLY), .TMO(TMO)) dut (
        .RESET  (rst),
        .CLK    (clk),
        .CE     (ce),
        .TYPE   (ty),
        .P1_BTN (p1),
        .P2_BTN (p2),
        .P3_BTN (p3),
        .P4_BTN (p4),
        .TH     (th),
        .TR     (tr),
        .DO     (w_do),
        .TL     (w_tl),
        .BUSY   (w_busy)
    );

    always #5 clk = ~clk;

    // Reference: build the whole frame as a list of nibbles, then index it
    function automatic logic [3:0] model_nib(input logic [7:0] t, input logic [47:0] bb, input int idx);
        logic [3:0]  q[$];
        logic [1:0]  pt;
        logic [11:0] b;
        q = '{4'h3, 4'hF, 4'h0, 4'h0};
        for (int p = 0; p < 4; p++) begin
            pt = t[2*p +: 2];
            q.push_back(pt == 2'b00 ? 4'h0 : (pt == 2'b01 ? 4'h1 : 4'hF));
        end
        for (int p = 0; p < 4; p++) begin
            pt = t[2*p +: 2];
            b  = bb[12*p +: 12];
            if (pt == 2'b00 || pt == 2'b01) begin
                q.push_back({b[B_RIGHT], b[B_LEFT], b[B_DOWN], b[B_UP]});
                q.push_back({b[B_START], b[B_A], b[B_C], b[B_B]});
            end
            if (pt == 2'b01) q.push_back({b[B_MODE], b[B_X], b[B_Y], b[B_Z]});
        end
        return (idx < q.size()) ? q[idx] : 4'hF;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start_frame();
        th = 1'b1;
        tr = 1'b1;
        tick(2);
        th = 1'b0;
        tick(1);
        s_ty  = ty;
        s_bb  = {p4, p3, p2, p1};
        m_idx = 0;
        m_tl  = 1'b1;
    endtask

    task automatic step(input string nm);
        tr = ~tr;
        tick(ACK_DLY + 2);
        if (tr != m_tl) begin
            if (m_idx < 31) m_idx++;
            m_tl = tr;
        end
        check({nm, "_do"}, {4'h0, w_do}, {4'h0, model_nib(s_ty, s_bb, m_idx)});
        check({nm, "_tl"}, {7'h0, w_tl}, {7'h0, m_tl});
    endtask

    task automatic dbl(input string nm);
        tr = ~tr;
        tick(2);
        tr = ~tr;
        tick(ACK_DLY + 2);
        check({nm, "_do"}, {4'h0, w_do}, {4'h0, model_nib(s_ty, s_bb, m_idx)});
        check({nm, "_tl"}, {7'h0, w_tl}, {7'h0, m_tl});
    endtask

    initial begin
        tbl = '{
            '{1'b0, 4'hF, 1'b0}, '{1'b1, 4'h0, 1'b1}, '{1'b0, 4'h0, 1'b0}, '{1'b1, 4'h0, 1'b1},
            '{1'b0, 4'h1, 1'b0}, '{1'b1, 4'hF, 1'b1}, '{1'b0, 4'hF, 1'b0}, '{1'b1, 4'hE, 1'b1},
            '{1'b0, 4'hF, 1'b0}, '{1'b1, 4'hF, 1'b1}, '{1'b0, 4'hF, 1'b0}, '{1'b1, 4'hE, 1'b1},
            '{1'b0, 4'hF, 1'b0}, '{1'b1, 4'hF, 1'b1}
        };

        rst = 1'b1; ce = 1'b1; th = 1'b1; tr = 1'b1;
        ty = 8'h00; p1 = 12'hFFF; p2 = 12'hFFF; p3 = 12'hFFF; p4 = 12'hFFF;
        tick(3);
        rst = 1'b0;
        tick(2);
        check("rst_do",   {4'h0, w_do},   8'h03);
        check("rst_tl",   {7'h0, w_tl},   8'h01);
        check("rst_busy", {7'h0, w_busy}, 8'h00);

        // Directed frame: pad1 3-button (UP), pad2 6-button (Z), pads 3/4 absent
        ty = 8'b11_11_01_00; p1 = 12'hFFE; p2 = 12'h7FF; p3 = 12'h000; p4 = 12'h000;
        start_frame();
        check("fall_do",   {4'h0, w_do},   8'h03);
        check("fall_tl",   {7'h0, w_tl},   8'h01);
        check("fall_busy", {7'h0, w_busy}, 8'h01);
        for (int i = 0; i < 14; i++) begin
            tr = tbl[i].tr;
            if (i == 0) begin
                tick(ACK_DLY);
                check("lat_early_do", {4'h0, w_do}, 8'h03);
                check("lat_early_tl", {7'h0, w_tl}, 8'h01);
                tick(2);
            end else begin
                tick(ACK_DLY + 2);
            end
            check($sformatf("tbl%0d_do", i + 1), {4'h0, w_do}, {4'h0, tbl[i].exp_do});
            check($sformatf("tbl%0d_tl", i + 1), {7'h0, w_tl}, {7'h0, tbl[i].exp_tl});
        end

        // Double toggle inside the ack window, then a normal advance
        start_frame();
        repeat (7) step("adv");
        dbl("dbl");
        step("after_dbl");
        check("after_dbl_e", {4'h0, w_do}, 8'h0E);

        // Abort at idx 9 with an ack pending
        step("to_idx9");
        tr = ~tr;
        tick(3);
        th = 1'b1;
        tick(1);
        check("abort_busy", {7'h0, w_busy}, 8'h00);
        check("abort_do",   {4'h0, w_do},   8'h03);
        check("abort_tl",   {7'h0, w_tl},   8'h01);
        tick(ACK_DLY + 2);
        check("abort_stale_tl", {7'h0, w_tl}, 8'h01);
        check("abort_stale_do", {4'h0, w_do}, 8'h03);
        start_frame();
        check("restart_do", {4'h0, w_do}, 8'h03);
        step("restart");

        // Timeout rewind at idx 6
        start_frame();
        repeat (6) step("pre_tmo");
        tick(TMO - 50);
        check("tmo_early_do", {4'h0, w_do}, {4'h0, model_nib(s_ty, s_bb, 6)});
        tick(60);
        m_idx = 0;
        check("tmo_do",   {4'h0, w_do},   8'h03);
        check("tmo_tl",   {7'h0, w_tl},   {7'h0, m_tl});
        check("tmo_busy", {7'h0, w_busy}, 8'h01);
        step("post_tmo1");
        step("post_tmo2");

        // CE low freezes the ack counter
        start_frame();
        repeat (7) step("pre_ce");
        tr = ~tr;
        tick(2);
        ce = 1'b0;
        tick(30);
        check("ce_hold_do", {4'h0, w_do}, 8'h0F);
        ce = 1'b1;
        tick(ACK_DLY - 3);
        check("ce_early_do", {4'h0, w_do}, 8'h0F);
        tick(3);
        m_idx = 8;
        m_tl  = tr;
        check("ce_adv_do", {4'h0, w_do}, 8'h0E);
        check("ce_adv_tl", {7'h0, w_tl}, {7'h0, m_tl});

        // Mid-frame input changes are ignored until the next TH fall
        ty = 8'h00; p1 = 12'hFFF;
        start_frame();
        p1 = 12'h000; ty = 8'h55;
        repeat (9) step("snap1");
        start_frame();
        repeat (9) step("snap2");

        // Randomized frames, with occasional double toggles
        for (int f = 0; f < 16; f++) begin
            ty = 8'($urandom);
            p1 = 12'($urandom); p2 = 12'($urandom); p3 = 12'($urandom); p4 = 12'($urandom);
            start_frame();
            for (int j = 0, n = $urandom_range(0, 24); j < n; j++) begin
                if ($urandom_range(0, 5) == 0) dbl("rnd_dbl");
                else                           step("rnd");
            end
        end

        // Index saturation: past 31 the data must stay F, never wrap to the header
        ty = 8'h55;
        start_frame();
        repeat (34) step("sat");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
